sum_loop_sequencer: RTL
=======================

SUM_LOOP_SEQUENCER -- requirements
Module: sum_loop_sequencer

Interface
REQ-001 Parameter: WDT_CYCLES, 64, watchdog limit in loop cycles; legal range 1..255; used only when SUM_SEQ_WATCHDOG_EN is defined.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to run one summation; sampled only in IDLE or ERR.
REQ-005 Port: abort  input  1  synchronous cancel of a running summation.
REQ-006 Port: iLe10  input  1  datapath status; 1 while loop index is less than or equal to 10.
REQ-007 Port: sumSrcMuxSel  output  1  0 selects constant 0, 1 selects adder result into sum register.
REQ-008 Port: iSrcMuxSel  output  1  0 selects constant 0, 1 selects adder result into index register.
REQ-009 Port: adderSrcMuxSel  output  1  0 gives adder sum+i, 1 gives adder i+1.
REQ-010 Port: sumLoad / iLoad / outLoad  output  1 each  register load enables.
REQ-011 Port: busy  output  1  high in INIT, CHECK, ADD, INC and OUTPUT.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: error  output  1  watchdog trip flag.
REQ-014 Port: iterCount  output  8  number of completed loop iterations; saturates at 255.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, CHECK, ADD, INC, OUTPUT, DONE and ERR; all outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
REQ-016 IDLE: all loads 0; start=1 -> INIT; otherwise remain in IDLE.
REQ-017 INIT: sumSrcMuxSel=0, iSrcMuxSel=0, sumLoad=1, iLoad=1; clear iterCount (and the watchdog counter) -> CHECK.
REQ-018 CHECK: all loads 0; iLe10=1 -> ADD; iLe10=0 -> OUTPUT.
REQ-019 ADD: sumSrcMuxSel=1, adderSrcMuxSel=0, sumLoad=1 -> INC.
REQ-020 INC: iSrcMuxSel=1, adderSrcMuxSel=1, iLoad=1; iterCount increments with saturation -> CHECK.
REQ-021 OUTPUT: outLoad=1 for exactly one cycle -> DONE.
REQ-022 DONE: done=1 for exactly one cycle -> IDLE; start in DONE is ignored.
REQ-023 Latency: done SHALL assert 3*N+4 cycles after the edge that samples start, where N is the number of CHECK cycles seeing iLe10=1.
REQ-024 abort=1 in INIT, CHECK, ADD, INC or OUTPUT SHALL force IDLE on the next edge, deassert every load in that next cycle, suppress outLoad and done, and hold iterCount.
REQ-025 Simultaneous start and abort SHALL be resolved with abort winning; the FSM stays in or returns to IDLE.
REQ-026 start or abort while busy SHALL be ignored except as defined in REQ-024.
REQ-027 Mux selects not named for a state SHALL be 0 in that state.

Reset
REQ-028 reset=1 SHALL take priority over all inputs; on the next edge the state becomes IDLE, all loads, mux selects, busy, done and error are 0, iterCount is 0, and the watchdog counter is 0.
REQ-029 Reset asserted mid-run SHALL abandon the run without an outLoad or done pulse.

Configuration
REQ-030 Macro SUM_SEQ_WATCHDOG_EN defined: an 8-bit counter SHALL clear in INIT and increment each CHECK, ADD or INC cycle.
REQ-031 When that counter equals WDT_CYCLES in a loop state, the next state SHALL be ERR instead of the normal transition.
REQ-032 ERR: all loads 0, busy=0, error=1; start -> INIT (error cleared in INIT); abort -> IDLE with error cleared.
REQ-033 Macro undefined: there SHALL be no counter and no ERR logic, error SHALL be tied to 0, and the FSM SHALL never enter ERR.

Verification
REQ-034 Reset, then start pulse; iLe10=1 for 11 CHECKs then 0 -> single outLoad, done at cycle 37 after start, iterCount=11.
REQ-035 iLe10=0 at the first CHECK -> OUTPUT then DONE; done at cycle 4; iterCount=0; exactly one sumLoad and one iLoad (from INIT).
REQ-036 abort during the 5th ADD -> IDLE next cycle; no outLoad or done; iterCount=4; a later start runs normally.
REQ-037 start and abort together in IDLE -> stays IDLE; busy remains 0.
REQ-038 With SUM_SEQ_WATCHDOG_EN and WDT_CYCLES=64, iLe10 stuck at 1 -> ERR entered at cycle 67 after start; error=1, no outLoad; start then clears error and restarts.
REQ-039 reset asserted in INC mid-run -> next cycle all outputs 0, iterCount=0; no done pulse.

Source files
------------

// File: rtl/sum_loop_sequencer.sv
// Moore FSM sequencing a summation datapath (mux selects, load enables); done pulses 3N+4 cycles after start.
// Optional loop watchdog and ERR state are built when SUM_SEQ_WATCHDOG_EN is defined; abort and reset cancel a run.
module sum_loop_sequencer #(
  parameter int unsigned WDT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       iLe10,
  output logic       sumSrcMuxSel,
  output logic       iSrcMuxSel,
  output logic       adderSrcMuxSel,
  output logic       sumLoad,
  output logic       iLoad,
  output logic       outLoad,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] iterCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_CHECK  = 3'd2,
    S_ADD    = 3'd3,
    S_INC    = 3'd4,
    S_OUTPUT = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_iter;
  logic       w_busy;
  logic       w_loop;

  // Legal limits are 1..255; anything else leaves this marker block in the hierarchy.
  if (WDT_CYCLES == 0 || WDT_CYCLES > 255) begin : g_wdt_cycles_illegal
  end

  assign w_loop = (r_state == S_CHECK) || (r_state == S_ADD) || (r_state == S_INC);

`ifdef SUM_SEQ_WATCHDOG_EN
  localparam logic [7:0] LP_WDT_LIMIT = 8'(WDT_CYCLES);

  logic [7:0] r_wdt;
  logic       w_wdt_trip;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdt <= 8'd0;
    end else if (r_state == S_INIT) begin
      r_wdt <= 8'd0;
    end else if (w_loop && (r_wdt != 8'hFF)) begin
      r_wdt <= r_wdt + 8'd1;
    end
  end

  assign w_wdt_trip = w_loop && (r_wdt == LP_WDT_LIMIT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs decode from r_state only; inputs affect nothing but w_next.
  always_comb begin
    w_next         = r_state;
    sumSrcMuxSel   = 1'b0;
    iSrcMuxSel     = 1'b0;
    adderSrcMuxSel = 1'b0;
    sumLoad        = 1'b0;
    iLoad          = 1'b0;
    outLoad        = 1'b0;
    w_busy         = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_next = S_INIT;
      end
      S_INIT: begin
        w_busy  = 1'b1;
        sumLoad = 1'b1;
        iLoad   = 1'b1;
        w_next  = S_CHECK;
      end
      S_CHECK: begin
        w_busy = 1'b1;
        w_next = iLe10 ? S_ADD : S_OUTPUT;
      end
      S_ADD: begin
        w_busy       = 1'b1;
        sumSrcMuxSel = 1'b1;
        sumLoad      = 1'b1;
        w_next       = S_INC;
      end
      S_INC: begin
        w_busy         = 1'b1;
        iSrcMuxSel     = 1'b1;
        adderSrcMuxSel = 1'b1;
        iLoad          = 1'b1;
        w_next         = S_CHECK;
      end
      S_OUTPUT: begin
        w_busy  = 1'b1;
        outLoad = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
`ifdef SUM_SEQ_WATCHDOG_EN
      S_ERR: begin
        error = 1'b1;
        if (abort) begin
          w_next = S_IDLE;
        end else if (start) begin
          w_next = S_INIT;
        end
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
`ifdef SUM_SEQ_WATCHDOG_EN
    if (w_wdt_trip) w_next = S_ERR;
`endif
    if (w_busy && abort) w_next = S_IDLE;
  end

  assign busy = w_busy;

  // An aborted INIT or INC leaves the iteration count untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iter <= 8'd0;
    end else if ((r_state == S_INIT) && !abort) begin
      r_iter <= 8'd0;
    end else if ((r_state == S_INC) && !abort && (r_iter != 8'hFF)) begin
      r_iter <= r_iter + 8'd1;
    end
  end

  assign iterCount = r_iter;

endmodule
